// File: rtl/warp_fetch_nport_pkg.sv
// Shared fetch-stage defaults and one-hot helpers.
// Used by the fetch pipe and the multi-port top.
package warp_fetch_nport_pkg;

  localparam int NUM_WARPS_D = 8;
  localparam int NUM_PORTS_D = 2;
  localparam int PC_W_D      = 32;
  localparam int IC_ADDR_W_D = 12;
  localparam int IC_LAT_D    = 2;

  // Helpers take a wide vector so any warp count up to 64 fits.
  localparam int MAX_WARPS = 64;
  typedef logic [MAX_WARPS-1:0] wvec_t;

  function automatic logic is_onehot(wvec_t v);
    return (v != '0) && ((v & (v - wvec_t'(1))) == '0);
  endfunction

  function automatic int oh_index(wvec_t v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_WARPS; i++)
      if (v[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/warp_fetch_nport_if.sv
// I-cache read port bundle: enable, per-port address, per-port data.
// master = fetch stage, slave = cache.
interface warp_fetch_nport_if #(
  parameter int NUM_PORTS = 2,
  parameter int IC_ADDR_W = 12
);

  logic                          ICache_En_IF;
  logic [NUM_PORTS*IC_ADDR_W-1:0] ICache_Addr_IF;
  logic [NUM_PORTS*32-1:0]        ICache_Rdata_IF;

  modport master (
    output ICache_En_IF,
    output ICache_Addr_IF,
    input  ICache_Rdata_IF
  );

  modport slave (
    input  ICache_En_IF,
    input  ICache_Addr_IF,
    output ICache_Rdata_IF
  );

endinterface

// File: rtl/warp_fetch_nport_fetch_port_pipe.sv
// One fetch port: PC select by one-hot grant, then an IC_LAT-deep
// valid/pc pipe with per-warp kill and global hold.
module fetch_port_pipe
  import warp_fetch_nport_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_D,
  parameter int PC_W      = PC_W_D,
  parameter int IC_ADDR_W = IC_ADDR_W_D,
  parameter int IC_LAT    = IC_LAT_D
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_WARPS-1:0]      grant,
  input  logic                      accept,
  input  logic                      stall,
  input  logic [NUM_WARPS-1:0]      flush,
  input  logic [NUM_WARPS*PC_W-1:0] pc_all,
  input  logic [31:0]               rdata,
  output logic [IC_ADDR_W-1:0]      addr,
  output logic [NUM_WARPS-1:0]      valid_out,
  output logic [31:0]               instr,
  output logic [PC_W-1:0]           pc_plus4,
  output logic [NUM_WARPS-1:0]      busy
);

  logic [NUM_WARPS-1:0] vq [IC_LAT];
  logic [PC_W-1:0]      pq [IC_LAT];
  logic [PC_W-1:0]      sel_pc;
  logic [NUM_WARPS-1:0] last_v;

  // Idle or malformed grant still reads PC0; the read is discarded.
  always_comb begin
    sel_pc = pc_all[PC_W-1:0];
    if (is_onehot(wvec_t'(grant)))
      sel_pc = pc_all[oh_index(wvec_t'(grant))*PC_W +: PC_W];
  end

  assign addr = sel_pc[IC_ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < IC_LAT; k++) begin
        vq[k] <= '0;
        pq[k] <= '0;
      end
    end else if (stall) begin
      // Held, but flushes still kill.
      for (int k = 0; k < IC_LAT; k++)
        vq[k] <= vq[k] & ~flush;
    end else begin
      vq[0] <= (accept ? grant : '0) & ~flush;
      pq[0] <= sel_pc;
      for (int k = 1; k < IC_LAT; k++) begin
        vq[k] <= vq[k-1] & ~flush;
        pq[k] <= pq[k-1];
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < IC_LAT; k++)
      busy = busy | vq[k];
  end

  assign last_v    = vq[IC_LAT-1];
  assign valid_out = last_v;
  assign instr     = (|last_v) ? rdata : '0;
  assign pc_plus4  = (|last_v) ? pq[IC_LAT-1] + PC_W'(4) : '0;

endmodule

// File: rtl/warp_fetch_nport.sv
// Multi-port warp fetch stage between RR scheduler and ID.
// Ports: clk/rst_n, I-cache bundle (ic), PCs, grants, flushes,
// stall in; instr/pc+4/valid, grant ack, inflight, grant error out.
module warp_fetch_nport
  import warp_fetch_nport_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_D,
  parameter int NUM_PORTS = NUM_PORTS_D,
  parameter int PC_W      = PC_W_D,
  parameter int IC_ADDR_W = IC_ADDR_W_D,
  parameter int IC_LAT    = IC_LAT_D
) (
  input  logic                           clk,
  input  logic                           rst_n,
  warp_fetch_nport_if.master             ic,
  input  logic [NUM_WARPS*PC_W-1:0]      PC_PC_IF,
  input  logic [NUM_PORTS*NUM_WARPS-1:0] GRT_raw_RR_IF,
  input  logic [NUM_WARPS-1:0]           UpdatePC_Qual1_SIMT_IF,
  input  logic [NUM_WARPS-1:0]           UpdatePC_Qual2_SIMT_IF,
  input  logic [NUM_PORTS*NUM_WARPS-1:0] UpdatePC_Qual3_ID_IF,
  input  logic                           Stall_ID_IF,
  output logic [NUM_PORTS*32-1:0]        Instr_IF_ID,
  output logic [NUM_PORTS*PC_W-1:0]      PC_plus4_IF_ID,
  output logic [NUM_PORTS*NUM_WARPS-1:0] Valid_IF_ID,
  output logic [NUM_PORTS-1:0]           Grant_Ack_IF_RR,
  output logic [NUM_WARPS-1:0]           Inflight_IF_RR,
  output logic                           Grant_Err_IF
);

  logic [NUM_WARPS-1:0]           gnt  [NUM_PORTS];
  logic [NUM_WARPS-1:0]           busy [NUM_PORTS];
  logic [NUM_PORTS-1:0]           oh;
  logic [NUM_PORTS-1:0]           bad;
  logic [NUM_PORTS-1:0]           dup;
  logic [NUM_PORTS-1:0]           ack;
  logic [NUM_WARPS-1:0]           flush;
  logic [NUM_PORTS*IC_ADDR_W-1:0] addr_v;
  logic                           err_q;

  always_comb begin
    flush = UpdatePC_Qual1_SIMT_IF | UpdatePC_Qual2_SIMT_IF;
    for (int p = 0; p < NUM_PORTS; p++)
      flush = flush
            | UpdatePC_Qual3_ID_IF[p*NUM_WARPS +: NUM_WARPS];
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_gnt
    assign gnt[p] = GRT_raw_RR_IF[p*NUM_WARPS +: NUM_WARPS];
    assign oh[p]  = is_onehot(wvec_t'(gnt[p]));
    assign bad[p] = !oh[p] && (gnt[p] != '0);
  end

  // Lower port wins a duplicate one-hot grant.
  always_comb begin
    dup = '0;
    ack = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < p; q++)
        if (oh[q] && oh[p] && gnt[q] == gnt[p])
          dup[p] = 1'b1;
      ack[p] = oh[p] && !dup[p] && !Stall_ID_IF
            && !(|(gnt[p] & flush));
    end
  end

  assign Grant_Ack_IF_RR = ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | (|bad) | (|dup);
  end

  assign Grant_Err_IF = err_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    fetch_port_pipe #(
      .NUM_WARPS (NUM_WARPS),
      .PC_W      (PC_W),
      .IC_ADDR_W (IC_ADDR_W),
      .IC_LAT    (IC_LAT)
    ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .grant     (gnt[p]),
      .accept    (ack[p]),
      .stall     (Stall_ID_IF),
      .flush     (flush),
      .pc_all    (PC_PC_IF),
      .rdata     (ic.ICache_Rdata_IF[p*32 +: 32]),
      .addr      (addr_v[p*IC_ADDR_W +: IC_ADDR_W]),
      .valid_out (Valid_IF_ID[p*NUM_WARPS +: NUM_WARPS]),
      .instr     (Instr_IF_ID[p*32 +: 32]),
      .pc_plus4  (PC_plus4_IF_ID[p*PC_W +: PC_W]),
      .busy      (busy[p])
    );
  end

  always_comb begin
    Inflight_IF_RR = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      Inflight_IF_RR = Inflight_IF_RR | busy[p];
  end

  assign ic.ICache_En_IF   = !Stall_ID_IF;
  assign ic.ICache_Addr_IF = addr_v;

endmodule
